// File: rtl/matrix_3x3_gen.sv
// matrix_3x3_gen: builds a registered 3x3 pixel window from a two-line buffer and delays frame syncs to match
// Ports: clk, rst_n (sync, active low); per_frame_vsync/href/clken + per_img_y in;
//   lb_ce/lb_din drive the line buffer, lb_tap0/lb_tap1 return lines N-1/N-2;
//   post_frame_vsync/href/clken out (1-cycle delayed), matrix_p11..p33 window, line_err sticky overrun flag.
// Optional: define MATRIX_BORDER_ZERO_EN to zero the window on pixels lacking two lines/columns of history.
module matrix_3x3_gen #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int DW        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic [DW-1:0] per_img_y,
  output logic          lb_ce,
  output logic [DW-1:0] lb_din,
  input  logic [DW-1:0] lb_tap0,
  input  logic [DW-1:0] lb_tap1,
  output logic          post_frame_vsync,
  output logic          post_frame_href,
  output logic          post_frame_clken,
  output logic [DW-1:0] matrix_p11,
  output logic [DW-1:0] matrix_p12,
  output logic [DW-1:0] matrix_p13,
  output logic [DW-1:0] matrix_p21,
  output logic [DW-1:0] matrix_p22,
  output logic [DW-1:0] matrix_p23,
  output logic [DW-1:0] matrix_p31,
  output logic [DW-1:0] matrix_p32,
  output logic [DW-1:0] matrix_p33,
  output logic          line_err
);
  localparam int HW = $clog2(IMG_HDISP) + 1;
  localparam int VW = $clog2(IMG_VDISP) + 1;
  localparam logic [HW-1:0] H_MAX = HW'(IMG_HDISP);
  localparam logic [VW-1:0] V_MAX = VW'(IMG_VDISP);
  logic acc, href_fall, vsync_rise;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  // Row vectors: index 0 = left (oldest column), index 2 = right (newest column).
  logic [2:0][DW-1:0] r1, r2, r3, n1, n2, n3, o1, o2, o3;
  assign acc        = per_frame_href & per_frame_clken;
  assign lb_ce      = acc;
  assign lb_din     = per_img_y;
  // The delayed sync outputs double as the edge-detector history.
  assign href_fall  = post_frame_href & ~per_frame_href;
  assign vsync_rise = per_frame_vsync & ~post_frame_vsync;
  assign n1 = {lb_tap1, r1[2:1]};
  assign n2 = {lb_tap0, r2[2:1]};
  assign n3 = {per_img_y, r3[2:1]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      line_err         <= 1'b0;
      h_cnt            <= '0;
      v_cnt            <= '0;
      r1               <= '0;
      r2               <= '0;
      r3               <= '0;
    end else begin
      post_frame_vsync <= per_frame_vsync;
      post_frame_href  <= per_frame_href;
      post_frame_clken <= acc;
      if (acc) begin
        r1 <= n1;
        r2 <= n2;
        r3 <= n3;
      end
      if (href_fall) h_cnt <= '0;
      else if (acc && h_cnt == H_MAX) line_err <= 1'b1;
      else if (acc) h_cnt <= h_cnt + HW'(1);
      if (vsync_rise) v_cnt <= '0;
      else if (href_fall && v_cnt != V_MAX) v_cnt <= v_cnt + VW'(1);
    end
  end
`ifdef MATRIX_BORDER_ZERO_EN
  logic complete;
  assign complete = (v_cnt >= VW'(2)) && (h_cnt >= HW'(2));
  // Separate output registers so zeroed borders never disturb the shift history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o1 <= '0;
      o2 <= '0;
      o3 <= '0;
    end else if (acc) begin
      o1 <= complete ? n1 : '0;
      o2 <= complete ? n2 : '0;
      o3 <= complete ? n3 : '0;
    end
  end
`else
  assign o1 = r1;
  assign o2 = r2;
  assign o3 = r3;
`endif
  assign matrix_p11 = o1[0];
  assign matrix_p12 = o1[1];
  assign matrix_p13 = o1[2];
  assign matrix_p21 = o2[0];
  assign matrix_p22 = o2[1];
  assign matrix_p23 = o2[2];
  assign matrix_p31 = o3[0];
  assign matrix_p32 = o3[1];
  assign matrix_p33 = o3[2];
endmodule

// File: tb/tb_matrix_3x3_gen.sv
// tb_matrix_3x3_gen: scoreboard bench for matrix_3x3_gen with a behavioural two-line buffer
module tb_matrix_3x3_gen;
  localparam int H = 8;
  localparam int V = 6;
  typedef struct {
    logic [71:0] win;
    int          row;
    int          col;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, vs = 1'b0, hr = 1'b0, ce = 1'b0;
  logic [7:0] y = 8'h00;
  logic lb_ce;
  logic [7:0] lb_din, tap0, tap1;
  logic post_vsync, post_href, post_clken, line_err;
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic [71:0] win;
  logic [7:0] lbuf [2*H] = '{default: 8'h00};
  logic [7:0] hist [$];
  exp_t q [$];
  int rst_idx = 0, row = 0, col = 0, checks = 0, errors = 0;
  logic pv = 1'b0, ph = 1'b0;
  logic m_acc = 1'b0, m_h = 1'b0, m_v = 1'b0, m_rst = 1'b0, started = 1'b0;
  logic [71:0] last = '0, cap34, cap22, cap20;

  matrix_3x3_gen #(.IMG_HDISP(H), .IMG_VDISP(V), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce), .per_img_y(y),
    .lb_ce(lb_ce), .lb_din(lb_din), .lb_tap0(tap0), .lb_tap1(tap1),
    .post_frame_vsync(post_vsync), .post_frame_href(post_href), .post_frame_clken(post_clken),
    .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
    .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
    .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
    .line_err(line_err)
  );

  always #5 clk = ~clk;
  assign win  = {p11, p12, p13, p21, p22, p23, p31, p32, p33};
  assign tap0 = lbuf[H-1];
  assign tap1 = lbuf[2*H-1];

  always @(posedge clk)
    if (lb_ce) begin
      for (int i = 2*H-1; i > 0; i--) lbuf[i] <= lbuf[i-1];
      lbuf[0] <= lb_din;
    end

  // Value held by a window slot that was shifted in at accept index t from a source d pixels back.
  function automatic logic [7:0] hv(input int t, input int d);
    if (t < rst_idx || t - d < 0) return 8'h00;
    return hist[t-d];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      checks++;
      if ({post_clken, post_href, post_vsync} !== (m_rst ? {m_acc, m_h, m_v} : 3'b000)) begin
        errors++;
        $display("FAIL post_delay got clken/href/vsync=%b want %b", {post_clken, post_href, post_vsync},
                 m_rst ? {m_acc, m_h, m_v} : 3'b000);
      end
      if (!m_rst) last = '0;
      if (post_clken) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL window_unexpected got strobe with win=%h want no strobe", win);
        end else begin
          e = q.pop_front();
          if (win !== e.win) begin
            errors++;
            $display("FAIL window r%0d c%0d got %h want %h", e.row, e.col, win, e.win);
          end
          last = e.win;
          if (e.row == 3 && e.col == 4) cap34 = win;
          if (e.row == 2 && e.col == 2) cap22 = win;
          if (e.row == 2 && e.col == 0) cap20 = win;
        end
      end else begin
        checks++;
        if (win !== last) begin
          errors++;
          $display("FAIL window_hold got %h want %h", win, last);
        end
      end
    end
    m_acc = hr & ce;
    m_h = hr;
    m_v = vs;
    m_rst = rst_n;
    started = 1'b1;
  end

  task automatic step(input logic v, input logic h, input logic c, input logic [7:0] d);
    exp_t e;
    int n;
    vs = v;
    hr = h;
    ce = c;
    y = d;
    if (h && c) begin
      hist.push_back(d);
      n = hist.size() - 1;
      e.win = {hv(n-2, 2*H), hv(n-1, 2*H), hv(n, 2*H),
               hv(n-2, H), hv(n-1, H), hv(n, H),
               hv(n-2, 0), hv(n-1, 0), hv(n, 0)};
`ifdef MATRIX_BORDER_ZERO_EN
      if (row < 2 || col < 2) e.win = '0;
`endif
      e.row = row;
      e.col = col;
      q.push_back(e);
      if (col < H) col++;
    end
    if (ph && !h) col = 0;
    if (v && !pv) row = 0;
    else if (ph && !h && row < V) row++;
    pv = v;
    ph = h;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ce = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    row = 0;
    col = 0;
    pv = 1'b0;
    ph = 1'b0;
    rst_idx = hist.size();
  endtask

  task automatic vsync_pulse();
    repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic line(input int r, input int len, input int per);
    int cnt;
    logic s;
    cnt = 0;
    for (int c = 0; cnt < len; c++) begin
      s = (c % per == 0);
      step(1'b0, 1'b1, s, {r[3:0], cnt[3:0]});
      if (s) cnt++;
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame(input int per);
    cap34 = 'x;
    cap22 = 'x;
    cap20 = 'x;
    vsync_pulse();
    for (int r = 0; r < V; r++) line(r, H, per);
  endtask

  task automatic check_cap34(input string tag);
    checks++;
    if (cap34 !== 72'h12_13_14_22_23_24_32_33_34) begin
      errors++;
      $display("FAIL %s_r3c4 got %h want 121314222324323334", tag, cap34);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({post_vsync, post_href, post_clken, line_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {post_vsync, post_href, post_clken, line_err});
    end
    checks++;
    if (win !== '0) begin
      errors++;
      $display("FAIL reset_window got %h want 0", win);
    end
    checks++;
    if (dut.h_cnt !== 0 || dut.v_cnt !== 0) begin
      errors++;
      $display("FAIL reset_counters got h=%0d v=%0d want 0 0", dut.h_cnt, dut.v_cnt);
    end
  endtask

  task automatic test_window();
    frame(1);
    check_cap34("window");
    checks++;
    if (cap22 !== 72'h00_01_02_10_11_12_20_21_22) begin
      errors++;
      $display("FAIL border_r2c2 got %h want 000102101112202122", cap22);
    end
    checks++;
`ifdef MATRIX_BORDER_ZERO_EN
    if (cap20 !== '0) begin
      errors++;
      $display("FAIL border_r2c0 got %h want 0", cap20);
    end
`else
    if (cap20[23:0] !== 24'h16_17_20) begin
      errors++;
      $display("FAIL border_r2c0 got p31..p33=%h want 161720", cap20[23:0]);
    end
`endif
  endtask

  task automatic test_sparse();
    frame(3);
    check_cap34("sparse");
  endtask

  task automatic test_line_err();
    vsync_pulse();
    for (int c = 0; c < H; c++) step(1'b0, 1'b1, 1'b1, {4'h0, 4'(c)});
    checks++;
    if (line_err !== 1'b0 || dut.h_cnt !== 4'd8) begin
      errors++;
      $display("FAIL line_err_8 got err=%b h=%0d want 0 8", line_err, dut.h_cnt);
    end
    step(1'b0, 1'b1, 1'b1, 8'h08);
    checks++;
    if (line_err !== 1'b1 || dut.h_cnt !== 4'd8) begin
      errors++;
      $display("FAIL line_err_9 got err=%b h=%0d want 1 8", line_err, dut.h_cnt);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int r = 1; r < V; r++) line(r, H, 1);
    frame(1);
    checks++;
    if (line_err !== 1'b1) begin
      errors++;
      $display("FAIL line_err_sticky got %b want 1", line_err);
    end
    do_reset();
    checks++;
    if (line_err !== 1'b0) begin
      errors++;
      $display("FAIL line_err_reset got %b want 0", line_err);
    end
  endtask

  task automatic test_mid_reset();
    vsync_pulse();
    for (int r = 0; r < 4; r++) line(r, H, 1);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b1, {4'h4, 4'(c)});
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (dut.v_cnt !== 4'd4 || dut.h_cnt !== 4'd3) begin
      errors++;
      $display("FAIL pre_reset_counters got v=%0d h=%0d want 4 3", dut.v_cnt, dut.h_cnt);
    end
    do_reset();
    checks++;
    if ({post_vsync, post_href, post_clken, line_err} !== 4'b0000 || win !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got flags=%b win=%h want 0", {post_vsync, post_href, post_clken, line_err}, win);
    end
    checks++;
    if (dut.h_cnt !== 0 || dut.v_cnt !== 0) begin
      errors++;
      $display("FAIL mid_reset_counters got h=%0d v=%0d want 0 0", dut.h_cnt, dut.v_cnt);
    end
    frame(1);
    check_cap34("after_reset");
  endtask

  initial begin
    test_reset();
    test_window();
    test_sparse();
    test_line_err();
    test_mid_reset();
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
